// File: rtl/program_fetch_arbiter.sv
// program_fetch_arbiter: shares program-memory read channels among fetchers.
// Define PROGRAM_FETCH_ARBITER_RR_EN for round-robin, else fixed priority.
module program_fetch_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1,
  parameter int ADDR_BITS     = 6,
  parameter int DATA_BITS     = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data
);

  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    READ_WAITING,
    READ_RELAYING
  } state_t;

  state_t                             state_q [NUM_CHANNELS];
  state_t                             state_d [NUM_CHANNELS];
  logic [CW-1:0]                      cur_q   [NUM_CHANNELS];
  logic [CW-1:0]                      cur_d   [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0]           busy_q, busy_d;
  logic [NUM_CONSUMERS-1:0]           rdy_q, rdy_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] data_q, data_d;
  logic [NUM_CHANNELS-1:0]            mvld_q, mvld_d;
  logic [NUM_CHANNELS*ADDR_BITS-1:0]  maddr_q, maddr_d;
`ifdef PROGRAM_FETCH_ARBITER_RR_EN
  logic [CW-1:0]                      ptr_q   [NUM_CHANNELS];
  logic [CW-1:0]                      ptr_d   [NUM_CHANNELS];
`endif

  logic          found;
  logic [CW-1:0] sel;
  logic [CW-1:0] cand;
  int            pos;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= IDLE;
        cur_q[c]   <= '0;
`ifdef PROGRAM_FETCH_ARBITER_RR_EN
        ptr_q[c]   <= '0;
`endif
      end
      busy_q  <= '0;
      rdy_q   <= '0;
      data_q  <= '0;
      mvld_q  <= '0;
      maddr_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        cur_q[c]   <= cur_d[c];
`ifdef PROGRAM_FETCH_ARBITER_RR_EN
        ptr_q[c]   <= ptr_d[c];
`endif
      end
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      data_q  <= data_d;
      mvld_q  <= mvld_d;
      maddr_q <= maddr_d;
    end
  end

  // Channels walk in index order; busy_d makes lower-channel grants
  // visible to higher channels in the same cycle.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    busy_d  = busy_q;
    rdy_d   = rdy_q;
    data_d  = data_q;
    mvld_d  = mvld_q;
    maddr_d = maddr_q;
`ifdef PROGRAM_FETCH_ARBITER_RR_EN
    ptr_d   = ptr_q;
`endif
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    pos   = 0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      unique case (state_q[c])
        IDLE: begin
          found = 1'b0;
          sel   = '0;
          for (int k = 0; k < NUM_CONSUMERS; k++) begin
`ifdef PROGRAM_FETCH_ARBITER_RR_EN
            pos = int'(ptr_q[c]) + k;
            if (pos >= NUM_CONSUMERS)
              pos = pos - NUM_CONSUMERS;
`else
            pos = k;
`endif
            cand = CW'(pos);
            if (!found && consumer_read_valid[cand]
                && !busy_d[cand]) begin
              found = 1'b1;
              sel   = cand;
            end
          end
          if (found) begin
            busy_d[sel] = 1'b1;
            cur_d[c]    = sel;
            mvld_d[c]   = 1'b1;
            maddr_d[c*ADDR_BITS +: ADDR_BITS] =
              consumer_read_address[int'(sel)*ADDR_BITS +: ADDR_BITS];
            state_d[c]  = READ_WAITING;
`ifdef PROGRAM_FETCH_ARBITER_RR_EN
            pos = int'(sel) + 1;
            if (pos >= NUM_CONSUMERS)
              pos = 0;
            ptr_d[c] = CW'(pos);
`endif
          end
        end
        READ_WAITING: begin
          if (mem_read_ready[c]) begin
            data_d[int'(cur_q[c])*DATA_BITS +: DATA_BITS] =
              mem_read_data[c*DATA_BITS +: DATA_BITS];
            mvld_d[c]       = 1'b0;
            rdy_d[cur_q[c]] = 1'b1;
            state_d[c]      = READ_RELAYING;
          end
        end
        READ_RELAYING: begin
          if (!consumer_read_valid[cur_q[c]]) begin
            rdy_d[cur_q[c]]  = 1'b0;
            busy_d[cur_q[c]] = 1'b0;
            state_d[c]       = IDLE;
          end
        end
        default: state_d[c] = IDLE;
      endcase
    end
  end

  assign consumer_read_ready = rdy_q;
  assign consumer_read_data  = data_q;
  assign mem_read_valid      = mvld_q;
  assign mem_read_address    = maddr_q;

endmodule

// File: tb/tb_program_fetch_arbiter.sv
// tb_program_fetch_arbiter: randomized and directed bench for the
// program fetch arbiter, one- and two-channel instances.
`timescale 1ns/1ps
module tb_program_fetch_arbiter;

  localparam int NC = 4;
  localparam int AB = 6;
  localparam int DB = 32;
`ifdef PROGRAM_FETCH_ARBITER_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NC-1:0]    cv, cr;
  logic [NC*AB-1:0] ca;
  logic [NC*DB-1:0] cd;
  logic [0:0]       mv, mr;
  logic [AB-1:0]    ma;
  logic [DB-1:0]    md;

  logic [NC-1:0]    cv2, cr2;
  logic [NC*AB-1:0] ca2;
  logic [NC*DB-1:0] cd2;
  logic [1:0]       mv2, mr2;
  logic [2*AB-1:0]  ma2;
  logic [2*DB-1:0]  md2;

  logic [DB-1:0] mem [64];

  int n_checks = 0;
  int n_fail   = 0;
  int model_ptr;
  int exp_owner;
  logic [NC-1:0] snap;
  logic mv_prev;
  int got[$];
  int pred[$];

  program_fetch_arbiter u_dut (
    .clk                   (clk),
    .reset                 (rst_n),
    .consumer_read_valid   (cv),
    .consumer_read_address (ca),
    .consumer_read_ready   (cr),
    .consumer_read_data    (cd),
    .mem_read_valid        (mv),
    .mem_read_address      (ma),
    .mem_read_ready        (mr),
    .mem_read_data         (md)
  );

  program_fetch_arbiter #(.NUM_CHANNELS(2)) u_dut2 (
    .clk                   (clk),
    .reset                 (rst_n),
    .consumer_read_valid   (cv2),
    .consumer_read_address (ca2),
    .consumer_read_ready   (cr2),
    .consumer_read_data    (cd2),
    .mem_read_valid        (mv2),
    .mem_read_address      (ma2),
    .mem_read_ready        (mr2),
    .mem_read_data         (md2)
  );

  // Program memory: ready and data one cycle after valid is sampled.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mr <= '0;
      md <= '0;
    end else begin
      mr[0] <= mv[0];
      if (mv[0]) md <= mem[ma];
    end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mr2 <= '0;
      md2 <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        mr2[c] <= mv2[c];
        if (mv2[c]) md2[c*DB +: DB] <= mem[ma2[c*AB +: AB]];
      end
    end

  // Arbitration rule: first requester from base, cyclically.
  function automatic int pick(input logic [NC-1:0] req, input int p);
    int base;
    base = RR_MODE ? p : 0;
    for (int k = 0; k < NC; k++) begin
      int i;
      i = (base + k) % NC;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic predict_order(input logic [NC-1:0] req);
    logic [NC-1:0] pend;
    int p;
    int g;
    pend = req;
    p = model_ptr;
    pred.delete();
    while (pend != 0) begin
      g = pick(pend, p);
      pred.push_back(g);
      pend[g] = 1'b0;
      p = (g + 1) % NC;
    end
  endtask

  task automatic tick();
    snap = cv;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_ptr = 0;
      mv_prev = 1'b0;
    end else begin
      if (mv[0] && !mv_prev) begin
        exp_owner = pick(snap, model_ptr);
        if (exp_owner >= 0) model_ptr = (exp_owner + 1) % NC;
      end
      mv_prev = mv[0];
    end
  endtask

  task automatic serve_all(input logic [NC-1:0] req,
                           input logic [NC*AB-1:0] addrs);
    int cyc;
    cyc = 0;
    got.delete();
    ca = addrs;
    cv = req;
    while (cv != 0 && cyc < 80) begin
      tick();
      cyc++;
      for (int i = 0; i < NC; i++) begin
        if (cv[i] && cr[i]) begin
          got.push_back(i);
          n_checks++;
          if (cd[i*DB +: DB] !== mem[ca[i*AB +: AB]]) begin
            n_fail++;
            $display("FAIL serve_data[%0d]: got %h expected %h",
                     i, cd[i*DB +: DB], mem[ca[i*AB +: AB]]);
          end
          n_checks++;
          if (i != exp_owner) begin
            n_fail++;
            $display("FAIL serve_owner: got %0d expected %0d",
                     i, exp_owner);
          end
          cv[i] = 1'b0;
        end
      end
    end
    n_checks++;
    if (cv != 0) begin
      n_fail++;
      $display("FAIL serve_timeout: pending %b expected 0000", cv);
    end
    cv = '0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cv = '0; ca = '0; cv2 = '0; ca2 = '0;
    model_ptr = 0; mv_prev = 1'b0; exp_owner = -1;
    #2;
    n_checks++;
    if (cr !== '0) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 0", cr);
    end
    n_checks++;
    if (cd !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", cd);
    end
    n_checks++;
    if (mv !== 1'b0 || mv2 !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mvalid: got %b/%b expected 0", mv, mv2);
    end
    n_checks++;
    if (ma !== '0) begin
      n_fail++; $display("FAIL reset_maddr: got %h expected 0", ma);
    end
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    ca[0 +: AB] = 6'h05;
    cv[0] = 1'b1;
    tick();
    n_checks++;
    if (mv[0] !== 1'b1 || ma !== 6'h05) begin
      n_fail++;
      $display("FAIL single_grant: got v=%b a=%h expected v=1 a=05",
               mv[0], ma);
    end
    tick();
    n_checks++;
    if (cr[0] !== 1'b0) begin
      n_fail++; $display("FAIL single_early: got %b expected 0", cr[0]);
    end
    tick();
    n_checks++;
    if (cr[0] !== 1'b1) begin
      n_fail++; $display("FAIL single_ready: got %b expected 1", cr[0]);
    end
    n_checks++;
    if (cd[31:0] !== 32'h12345678) begin
      n_fail++;
      $display("FAIL single_data: got %h expected 12345678", cd[31:0]);
    end
    repeat (2) begin
      tick();
      n_checks++;
      if (cr[0] !== 1'b1) begin
        n_fail++; $display("FAIL single_hold: got %b expected 1", cr[0]);
      end
    end
    cv[0] = 1'b0;
    tick();
    n_checks++;
    if (cr[0] !== 1'b0 || mv[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release: got r=%b v=%b expected 0 0",
               cr[0], mv[0]);
    end
    tick();
  endtask

  task automatic test_contention();
    serve_all(4'b1111, {6'd4, 6'd3, 6'd2, 6'd1});
    n_checks++;
    if (got.size() != 4) begin
      n_fail++;
      $display("FAIL cont_count: got %0d expected 4", got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (got[k] != k) begin
          n_fail++;
          $display("FAIL cont_order[%0d]: got %0d expected %0d",
                   k, got[k], k);
        end
      end
    end
    serve_all(4'b0001, {6'd0, 6'd0, 6'd0, 6'd7});
    predict_order(4'b1011);
    serve_all(4'b1011, {6'd12, 6'd0, 6'd11, 6'd10});
    n_checks++;
    if (got.size() != 3) begin
      n_fail++;
      $display("FAIL cont2_count: got %0d expected 3", got.size());
    end else begin
      n_checks++;
      if (got[0] != (RR_MODE ? 1 : 0)) begin
        n_fail++;
        $display("FAIL cont2_first: got %0d expected %0d",
                 got[0], RR_MODE ? 1 : 0);
      end
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (got[k] != pred[k]) begin
          n_fail++;
          $display("FAIL cont2_order[%0d]: got %0d expected %0d",
                   k, got[k], pred[k]);
        end
      end
    end
  endtask

  task automatic test_two_channel();
    ca2[0 +: AB]  = 6'd20;
    ca2[AB +: AB] = 6'd21;
    cv2 = 4'b0011;
    tick();
    n_checks++;
    if (mv2 !== 2'b11 || ma2 !== {6'd21, 6'd20}) begin
      n_fail++;
      $display("FAIL two_grant: got v=%b a=%h expected v=11 a=%h",
               mv2, ma2, {6'd21, 6'd20});
    end
    tick();
    n_checks++;
    if (cr2 !== 4'b0000) begin
      n_fail++; $display("FAIL two_early: got %b expected 0000", cr2);
    end
    tick();
    n_checks++;
    if (cr2 !== 4'b0011) begin
      n_fail++; $display("FAIL two_ready: got %b expected 0011", cr2);
    end
    n_checks++;
    if (cd2[63:0] !== {mem[21], mem[20]}) begin
      n_fail++;
      $display("FAIL two_data: got %h expected %h",
               cd2[63:0], {mem[21], mem[20]});
    end
    cv2 = '0;
    tick();
    n_checks++;
    if (cr2 !== 4'b0000 || mv2 !== 2'b00) begin
      n_fail++;
      $display("FAIL two_release: got r=%b v=%b expected 0", cr2, mv2);
    end
    tick();
  endtask

  task automatic test_slow_release();
    int cyc;
    cyc = 0;
    ca[2*AB +: AB] = 6'd9;
    cv = 4'b0100;
    while (!cr[2] && cyc < 10) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc != 3 || cr[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL slow_latency: got %0d edges expected 3", cyc);
    end
    ca[1*AB +: AB] = 6'd17;
    cv[1] = 1'b1;
    repeat (5) begin
      tick();
      n_checks++;
      if (cr[2] !== 1'b1 || mv[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL slow_hold: got r=%b v=%b expected r=1 v=0",
                 cr[2], mv[0]);
      end
    end
    cv[2] = 1'b0;
    tick();
    n_checks++;
    if (cr[2] !== 1'b0 || mv[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL slow_drop: got r=%b v=%b expected 0 0",
               cr[2], mv[0]);
    end
    tick();
    n_checks++;
    if (mv[0] !== 1'b1 || ma !== 6'd17) begin
      n_fail++;
      $display("FAIL slow_regrant: got v=%b a=%h expected v=1 a=11",
               mv[0], ma);
    end
    cyc = 0;
    while (!cr[1] && cyc < 10) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cr[1] !== 1'b1 || cd[1*DB +: DB] !== mem[17]) begin
      n_fail++;
      $display("FAIL slow_second: got r=%b d=%h expected 1 %h",
               cr[1], cd[1*DB +: DB], mem[17]);
    end
    cv = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    int cyc;
    ca[3*AB +: AB] = 6'd33;
    cv = 4'b1000;
    tick();
    tick();
    n_checks++;
    if (mv[0] !== 1'b1 || cr !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_waiting: got v=%b r=%b expected 1 0000",
               mv[0], cr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (mv !== 1'b0 || cr !== '0 || cd !== '0 || ma !== '0) begin
      n_fail++;
      $display("FAIL mid_async: got v=%b r=%b d=%h expected 0",
               mv, cr, cd);
    end
    model_ptr = 0;
    mv_prev = 1'b0;
    cv = '0;
    @(posedge clk);
    #4 rst_n = 1'b1;
    tick();
    cv = 4'b1000;
    cyc = 0;
    while (!cr[3] && cyc < 10) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc != 3 || cd[3*DB +: DB] !== mem[33]) begin
      n_fail++;
      $display("FAIL mid_fresh: got %0d edges d=%h expected 3 %h",
               cyc, cd[3*DB +: DB], mem[33]);
    end
    cv = '0;
    tick();
    tick();
  endtask

  task automatic test_random();
    int st[NC];
    int cnt[NC];
    int served;
    int bound;
    served = 0;
    bound = RR_MODE ? 60 : 300;
    for (int i = 0; i < NC; i++) begin
      st[i] = 0;
      cnt[i] = 0;
    end
    for (int cyc = 0; cyc < 900; cyc++) begin
      tick();
      for (int i = 0; i < NC; i++) begin
        case (st[i])
          0: if (cyc < 600 && $urandom_range(0, 15) == 0) begin
            ca[i*AB +: AB] = 6'($urandom);
            cv[i] = 1'b1;
            st[i] = 1;
            cnt[i] = 0;
          end
          1: begin
            cnt[i]++;
            if (cr[i]) begin
              served++;
              n_checks++;
              if (cd[i*DB +: DB] !== mem[ca[i*AB +: AB]]) begin
                n_fail++;
                $display("FAIL rand_data[%0d]: got %h expected %h",
                         i, cd[i*DB +: DB], mem[ca[i*AB +: AB]]);
              end
              n_checks++;
              if (i != exp_owner) begin
                n_fail++;
                $display("FAIL rand_owner: got %0d expected %0d",
                         i, exp_owner);
              end
              st[i] = 2;
              cnt[i] = $urandom_range(0, 2);
            end else if (cnt[i] > bound) begin
              n_checks++;
              n_fail++;
              $display("FAIL rand_starve[%0d]: waited %0d limit %0d",
                       i, cnt[i], bound);
              cv[i] = 1'b0;
              st[i] = 0;
            end
          end
          default: begin
            if (cnt[i] == 0) begin
              cv[i] = 1'b0;
              st[i] = 0;
            end else begin
              cnt[i]--;
            end
          end
        endcase
      end
    end
    n_checks++;
    if (cv !== '0 || cr !== '0 || served < 10) begin
      n_fail++;
      $display("FAIL rand_drain: got v=%b r=%b served=%0d",
               cv, cr, served);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[5] = 32'h12345678;
    test_reset();
    test_single();
    test_contention();
    test_two_channel();
    test_slow_release();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
